game_status_ctrl: RTL and testbench

GAME_STATUS_CTRL -- requirements
Module: game_status_ctrl

---
 rtl/game_status_ctrl.sv | 131 +++++++++++++
 tb/tb_game_status_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/game_status_ctrl.sv
// Game status FSM: START/PLAY/DYING/WIN/GAMEOVER with frame-debounced deaths and Enter edge acceptance.
// Latency: outputs registered, one Clk after the trigger; frame_tick is 3 Clk after a raw frame_clk rise.
module game_status_ctrl #(
    parameter int          DEATH_FRAMES = 2,
    parameter int          HOLD_FRAMES  = 60,
    parameter logic [7:0]  ENTER_KEY    = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       is_dead_boy,
    input  logic       is_dead_girl,
    input  logic       level_done,
    input  logic [7:0] keycode,
    output logic [3:0] status,
    output logic       freeze,
    output logic [1:0] dead_who,
    output logic       restart
);
    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [DW-1:0] D_MAX  = DW'(DEATH_FRAMES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_FRAMES - 1);

    localparam logic [3:0] ST_START = 4'b0000;
    localparam logic [3:0] ST_PLAY  = 4'b0001;
    localparam logic [3:0] ST_DYING = 4'b0010;
    localparam logic [3:0] ST_WIN   = 4'b0100;
    localparam logic [3:0] ST_OVER  = 4'b1000;

    logic          sync0, sync1, sync2, frame_tick;
    logic          armed, enter_ok;
    logic [DW-1:0] boy_cnt, girl_cnt, boy_inc, girl_inc;
    logic [HW-1:0] hold_cnt;
    logic          boy_conf, girl_conf;
    logic [3:0]    state_nxt;
    logic [1:0]    dead_nxt;
    logic          restart_nxt, clr_death, clr_hold;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync0      <= frame_clk;
            sync1      <= sync0;
            sync2      <= sync1;
            frame_tick <= sync1 & ~sync2;
        end
    end

    // Armed only after a Clk without Enter, so a held key is accepted once.
    always_ff @(posedge Clk) begin
        if (Reset) armed <= 1'b0;
        else       armed <= (keycode != ENTER_KEY);
    end

    assign enter_ok  = armed && (keycode == ENTER_KEY);
    assign boy_inc   = (boy_cnt  == D_MAX) ? D_MAX : boy_cnt  + DW'(1);
    assign girl_inc  = (girl_cnt == D_MAX) ? D_MAX : girl_cnt + DW'(1);
    assign boy_conf  = frame_tick && is_dead_boy  && (boy_inc  == D_MAX);
    assign girl_conf = frame_tick && is_dead_girl && (girl_inc == D_MAX);

    always_comb begin
        state_nxt   = status;
        dead_nxt    = dead_who;
        restart_nxt = 1'b0;
        clr_death   = 1'b0;
        clr_hold    = 1'b0;
        case (status)
            ST_START: if (enter_ok) begin
                state_nxt   = ST_PLAY;
                restart_nxt = 1'b1;
                clr_death   = 1'b1;
            end
            ST_PLAY: if (frame_tick) begin
                // A death on the same tick as level_done takes priority.
                if (boy_conf || girl_conf) begin
                    state_nxt = ST_DYING;
                    dead_nxt  = {girl_conf, boy_conf};
                    clr_hold  = 1'b1;
                end else if (level_done) begin
                    state_nxt = ST_WIN;
                end
            end
            ST_DYING: if (frame_tick && hold_cnt == H_LAST) state_nxt = ST_OVER;
            ST_OVER: if (enter_ok) begin
                state_nxt   = ST_PLAY;
                restart_nxt = 1'b1;
                dead_nxt    = 2'b00;
                clr_death   = 1'b1;
            end
            ST_WIN: if (enter_ok) begin
                state_nxt   = ST_START;
                restart_nxt = 1'b1;
            end
            default: state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || clr_death) begin
            boy_cnt  <= '0;
            girl_cnt <= '0;
        end else if (status == ST_PLAY && frame_tick) begin
            boy_cnt  <= is_dead_boy  ? boy_inc  : '0;
            girl_cnt <= is_dead_girl ? girl_inc : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || clr_hold) hold_cnt <= '0;
        else if (status == ST_DYING && frame_tick && hold_cnt != H_LAST) hold_cnt <= hold_cnt + HW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            status   <= ST_START;
            freeze   <= 1'b1;
            dead_who <= 2'b00;
            restart  <= 1'b0;
        end else begin
            status   <= state_nxt;
            freeze   <= (state_nxt != ST_PLAY);
            dead_who <= dead_nxt;
            restart  <= restart_nxt;
        end
    end
endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl: expected output changes are queued with the Clk edge they must
// appear on; a monitor pops and compares every time the DUT's output vector changes.
module tb_game_status_ctrl;
    localparam logic [7:0] ENTER = 8'h28;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       is_dead_boy = 1'b0;
    logic       is_dead_girl = 1'b0;
    logic       level_done = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [3:0] status;
    logic       freeze;
    logic [1:0] dead_who;
    logic       restart;

    game_status_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .is_dead_boy(is_dead_boy), .is_dead_girl(is_dead_girl), .level_done(level_done),
        .keycode(keycode), .status(status), .freeze(freeze), .dead_who(dead_who), .restart(restart)
    );

    initial forever #5 Clk = ~Clk;

    int pc = 0;
    always @(posedge Clk) pc <= pc + 1;

    typedef struct packed {
        logic [3:0]  st;
        logic        frz;
        logic [1:0]  dw;
        logic        rs;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic expect_at(input logic [3:0] st, input logic frz, input logic [1:0] dw,
                             input logic rs, input int cyc);
        exp_t e;
        e.st = st; e.frz = frz; e.dw = dw; e.rs = rs; e.cyc = 32'(cyc);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One frame_clk period; tick lands on edge pc+4 of the call, inputs held throughout.
    task automatic frame(input logic boy, input logic girl, input logic lvl);
        is_dead_boy = boy; is_dead_girl = girl; level_done = lvl;
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
        is_dead_boy = 1'b0; is_dead_girl = 1'b0; level_done = 1'b0;
    endtask

    task automatic enter_press(input logic [3:0] st, input logic frz, input logic [1:0] dw);
        expect_at(st, frz, dw, 1'b1, pc + 1);
        expect_at(st, frz, dw, 1'b0, pc + 2);
        keycode = ENTER;
        step();
        keycode = 8'h00;
        step();
    endtask

    // Monitor: every change of the output vector must match the head of the queue, at its edge.
    initial begin
        logic [7:0] prev, cur;
        exp_t e;
        prev = 8'hFF;
        forever begin
            @(negedge Clk);
            cur = {status, freeze, dead_who, restart};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change edge=%0d got st=%b frz=%b dw=%b rs=%b",
                             pc, status, freeze, dead_who, restart);
                end else begin
                    e = q.pop_front();
                    if (cur !== {e.st, e.frz, e.dw, e.rs} || pc != int'(e.cyc)) begin
                        failures++;
                        $display("FAIL output_change got st=%b frz=%b dw=%b rs=%b edge=%0d want st=%b frz=%b dw=%b rs=%b edge=%0d",
                                 status, freeze, dead_who, restart, pc, e.st, e.frz, e.dw, e.rs, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        // Reset state
        expect_at(4'b0000, 1'b1, 2'b00, 1'b0, 1);
        repeat (3) step();
        Reset = 1'b0;
        step();

        // START -> PLAY
        enter_press(4'b0001, 1'b0, 2'b00);

        // Single-frame glitch must not kill; two frames must
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        expect_at(4'b0010, 1'b1, 2'b01, 1'b0, pc + 4);
        frame(1'b1, 1'b0, 1'b0);

        // DYING hold: GAMEOVER on the 60th tick; death inputs ignored meanwhile
        for (int i = 0; i < 59; i++) frame(i < 3, i < 3, 1'b0);
        expect_at(4'b1000, 1'b1, 2'b01, 1'b0, pc + 4);
        frame(1'b0, 1'b0, 1'b0);

        // GAMEOVER -> PLAY clears dead_who
        step();
        enter_press(4'b0001, 1'b0, 2'b00);

        // Girl death and level_done on same tick: death wins
        frame(1'b0, 1'b1, 1'b0);
        expect_at(4'b0010, 1'b1, 2'b10, 1'b0, pc + 4);
        frame(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 59; i++) frame(1'b0, 1'b0, 1'b0);
        // Enter held across GAMEOVER entry is not accepted
        keycode = ENTER;
        expect_at(4'b1000, 1'b1, 2'b10, 1'b0, pc + 4);
        frame(1'b0, 1'b0, 1'b0);
        repeat (5) step();
        keycode = 8'h00;
        step();
        enter_press(4'b0001, 1'b0, 2'b00);

        // PLAY -> WIN -> START
        expect_at(4'b0100, 1'b1, 2'b00, 1'b0, pc + 4);
        frame(1'b0, 1'b0, 1'b1);
        enter_press(4'b0000, 1'b1, 2'b00);

        // Both characters die on the same tick
        enter_press(4'b0001, 1'b0, 2'b00);
        frame(1'b1, 1'b1, 1'b0);
        expect_at(4'b0010, 1'b1, 2'b11, 1'b0, pc + 4);
        frame(1'b1, 1'b1, 1'b0);

        // Reset mid-DYING (hold counter 30), Enter held through reset
        for (int i = 0; i < 30; i++) frame(1'b0, 1'b0, 1'b0);
        keycode = ENTER;
        Reset = 1'b1;
        expect_at(4'b0000, 1'b1, 2'b00, 1'b0, pc + 1);
        repeat (2) step();
        Reset = 1'b0;
        repeat (4) step();
        keycode = 8'h00;
        step();
        enter_press(4'b0001, 1'b0, 2'b00);

        // Frame edges in PLAY with no events produce no change
        frame(1'b0, 1'b0, 1'b0);
        repeat (5) step();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got %0d outstanding want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
